// File: rtl/dadda_mac_8x8.sv
// dadda_mac_8x8: streaming multiply-accumulate stage.
// Unsigned 8x8 operand pairs enter over valid/ready. They are registered (S1),
// multiplied combinationally, and the exact 16-bit product is registered (S2).
// LEN consecutive products are summed modulo 2^ACC_W, with a sticky carry flag.
// Each finished sum is presented on a valid/ready output port.

module dadda_16x16_uncompressed (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // Sum the eight shifted partial-product rows into the exact 16-bit product.
    always_comb begin
        p = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + ({8'd0, a} << i);
            end else begin
                p = p + 16'd0;
            end
        end
    end

endmodule

module dadda_mac_8x8 #(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] LEN_M1 = 8'(LEN - 1);

    state_t           state;
    logic [7:0]       cnt;

    // S1 stage
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic             v1;
    logic             l1;

    // S2 stage
    logic [15:0]      p_q;
    logic             v2;
    logic             l2;

    // Accumulator
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;

    logic             accept_s;
    logic             last_pair_s;
    logic [15:0]      prod_s;
    logic [ACC_W:0]   p_ext_s;
    logic [ACC_W:0]   sum_s;

    dadda_16x16_uncompressed u_mult (
        .a (a_q),
        .b (b_q),
        .p (prod_s)
    );

    // Handshake decode and the running sum including the product now in S2.
    always_comb begin
        accept_s    = in_valid & in_ready;
        last_pair_s = (cnt == LEN_M1);
        p_ext_s     = {(ACC_W + 1){1'b0}};
        p_ext_s[15:0] = p_q;
        sum_s       = {1'b0, acc} + p_ext_s;
    end

    // Accept counter plus the S1 and S2 pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
            a_q <= 8'd0;
            b_q <= 8'd0;
            v1  <= 1'b0;
            l1  <= 1'b0;
            p_q <= 16'd0;
            v2  <= 1'b0;
            l2  <= 1'b0;
        end else begin
            if (accept_s) begin
                a_q <= in_a;
                b_q <= in_b;
                if (last_pair_s) begin
                    cnt <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                a_q <= a_q;
                b_q <= b_q;
                cnt <= cnt;
            end
            v1  <= accept_s;
            l1  <= accept_s & last_pair_s;
            p_q <= prod_s;
            v2  <= v1;
            l2  <= l1;
        end
    end

    // Accumulate each valid product; clear on the product that closes a group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= {ACC_W{1'b0}};
            ovf_acc <= 1'b0;
        end else if (v2) begin
            if (l2) begin
                acc     <= {ACC_W{1'b0}};
                ovf_acc <= 1'b0;
            end else begin
                acc     <= sum_s[ACC_W-1:0];
                ovf_acc <= ovf_acc | sum_s[ACC_W];
            end
        end else begin
            acc     <= acc;
            ovf_acc <= ovf_acc;
        end
    end

    // Control FSM driving the registered handshake outputs and the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= {ACC_W{1'b0}};
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                ACCUM: begin
                    if (accept_s && last_pair_s) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end else begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (v2 && l2) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= sum_s[ACC_W-1:0];
                        out_ovf   <= ovf_acc | sum_s[ACC_W];
                    end else begin
                        state     <= DRAIN;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        state     <= HOLD;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dadda_mac_8x8.sv
// Testbench for dadda_mac_8x8: two instances (ACC_W=24 and ACC_W=17, LEN=4)
// driven in lockstep; table vectors, reset corner cases and random groups.

module tb_dadda_mac_8x8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_ready;

    logic        rdy24;
    logic        vld24;
    logic [23:0] od24;
    logic        ovf24;
    logic        rdy17;
    logic        vld17;
    logic [16:0] od17;
    logic        ovf17;

    int n_checks;
    int n_err;

    logic [7:0] ga   [4];
    logic [7:0] gb   [4];
    int         ggap [4];

    typedef struct {
        logic [3:0][7:0] a;     // pair k operand a is a[k]
        logic [3:0][7:0] b;
        logic [3:0][3:0] gap;   // idle cycles before pair k
        int              hold;  // cycles out_ready stays low after out_valid
        int              exp_sum;
    } vec_t;

    vec_t tbl [7];

    dadda_mac_8x8 #(.LEN(4), .ACC_W(24)) dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy24),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (vld24),
        .out_ready (out_ready),
        .out_data  (od24),
        .out_ovf   (ovf24)
    );

    dadda_mac_8x8 #(.LEN(4), .ACC_W(17)) dut17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy17),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (vld17),
        .out_ready (out_ready),
        .out_data  (od17),
        .out_ovf   (ovf17)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a group is the plain integer dot product of its pairs.
    function automatic int model_sum();
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s = s + int'(ga[k]) * int'(gb[k]);
        end
        return s;
    endfunction

    // Enter and leave at a falling edge; returns one falling edge after the accept.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        int   tries;
        logic done;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        done = 1'b0;
        tries = 0;
        while (!done && tries < 50) begin
            if (rdy24) begin
                @(posedge clk);
                done = 1'b1;
            end
            @(negedge clk);
            tries++;
        end
        in_valid = 1'b0;
        check("accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_group(input string tag, input int hold, input int exp_sum);
        logic [31:0] e24;
        logic [31:0] e17;
        logic        x24;
        logic        x17;
        e24 = exp_sum & 32'h00FF_FFFF;
        e17 = exp_sum & 32'h0001_FFFF;
        x24 = (exp_sum >= 32'd16777216);
        x17 = (exp_sum >= 32'd131072);
        for (int k = 0; k < 4; k++) begin
            send_pair(ga[k], gb[k], ggap[k]);
        end
        // Now one half-cycle after the last handshake edge E.
        check({tag, "_valid_e0"}, {31'd0, vld24}, 32'd0);
        @(negedge clk);
        check({tag, "_valid_e1"}, {31'd0, vld24}, 32'd0);
        check({tag, "_ready_drain"}, {31'd0, rdy24}, 32'd0);
        @(negedge clk);
        check({tag, "_valid24"}, {31'd0, vld24}, 32'd1);
        check({tag, "_valid17"}, {31'd0, vld17}, 32'd1);
        check({tag, "_data24"}, {8'd0, od24}, e24);
        check({tag, "_ovf24"}, {31'd0, ovf24}, {31'd0, x24});
        check({tag, "_data17"}, {15'd0, od17}, e17);
        check({tag, "_ovf17"}, {31'd0, ovf17}, {31'd0, x17});
        check({tag, "_ready_hold"}, {31'd0, rdy24}, 32'd0);
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                @(negedge clk);
                check({tag, "_hold_valid"}, {31'd0, vld24}, 32'd1);
                check({tag, "_hold_data"}, {8'd0, od24}, e24);
                check({tag, "_hold_ready"}, {31'd0, rdy24}, 32'd0);
            end
            out_ready = 1'b1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'd0, vld24}, 32'd0);
        check({tag, "_ready_back24"}, {31'd0, rdy24}, 32'd1);
        check({tag, "_ready_back17"}, {31'd0, rdy17}, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, rdy24}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, vld24}, 32'd0);
        check({tag, "_out_data"}, {8'd0, od24}, 32'd0);
        check({tag, "_out_ovf"}, {31'd0, ovf24}, 32'd0);
        check({tag, "_in_ready17"}, {31'd0, rdy17}, 32'd0);
        check({tag, "_out_data17"}, {15'd0, od17}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_err = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 8'd0;
        in_b = 8'd0;
        out_ready = 1'b1;

        tbl[0] = '{a: {8'd255, 8'd255, 8'd255, 8'd255}, b: {8'd255, 8'd255, 8'd255, 8'd255},
                   gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp_sum: 260100};
        tbl[1] = '{a: {8'd1, 8'd1, 8'd1, 8'd1}, b: {8'd1, 8'd1, 8'd1, 8'd1},
                   gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp_sum: 4};
        tbl[2] = '{a: {8'd7, 8'd5, 8'd3, 8'd1}, b: {8'd8, 8'd6, 8'd4, 8'd2},
                   gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp_sum: 100};
        tbl[3] = '{a: {8'd1, 8'd0, 8'd0, 8'd0}, b: {8'd1, 8'd0, 8'd0, 8'd0},
                   gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp_sum: 1};
        tbl[4] = '{a: {8'd7, 8'd5, 8'd3, 8'd1}, b: {8'd8, 8'd6, 8'd4, 8'd2},
                   gap: {4'd0, 4'd3, 4'd0, 4'd0}, hold: 0, exp_sum: 100};
        tbl[5] = '{a: {8'd7, 8'd5, 8'd3, 8'd1}, b: {8'd8, 8'd6, 8'd4, 8'd2},
                   gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 5, exp_sum: 100};
        tbl[6] = '{a: {8'd1, 8'd1, 8'd1, 8'd1}, b: {8'd1, 8'd1, 8'd1, 8'd1},
                   gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp_sum: 4};

        // Power-up reset.
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_to_accum_ready", {31'd0, rdy24}, 32'd1);

        // Table-driven groups.
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < 4; k++) begin
                ga[k] = tbl[t].a[k];
                gb[k] = tbl[t].b[k];
                ggap[k] = int'(tbl[t].gap[k]);
            end
            run_group($sformatf("tbl%0d", t), tbl[t].hold, tbl[t].exp_sum);
        end

        // Reset in the middle of a group discards it.
        send_pair(8'd10, 8'd10, 0);
        send_pair(8'd10, 8'd10, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("midrst");
        @(negedge clk);
        check("midrst_ready_back", {31'd0, rdy24}, 32'd1);
        check("midrst_no_output", {31'd0, vld24}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            ga[k] = 8'd2;
            gb[k] = 8'd3;
            ggap[k] = 0;
        end
        run_group("midrst_grp", 0, 24);

        // Randomized groups against the dot-product model.
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 4; k++) begin
                ga[k] = 8'($urandom);
                gb[k] = 8'($urandom);
                ggap[k] = int'($urandom_range(0, 2));
            end
            if (r < 4) begin
                ga[0] = 8'd255; gb[0] = 8'd255;
                ga[1] = 8'd255; gb[1] = 8'd255;
            end
            run_group($sformatf("rnd%0d", r), int'($urandom_range(0, 2)), model_sum());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dadda_mac_8x8.md
# dadda_mac_8x8

Pipelined multiply-accumulate stage downstream of the combinational 8x8 Dadda multiplier (`dadda_16x16_uncompressed`). It accepts unsigned 8-bit operand pairs over a valid/ready handshake, registers them in front of the multiplier, and registers the 16-bit product. It accumulates LEN consecutive products into an ACC_W-bit sum and presents each finished sum on a valid/ready output port. It turns the bare multiplier into a streaming dot-product engine.

## Interface
- `LEN`, 4: products per result; legal range 1..255.
- `ACC_W`, 24: accumulator and result width; legal range 16..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset. Sampled only on the rising edge of `clk`; there is no asynchronous path.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block accepts a pair this cycle; registered.
- `in_a` in 8: unsigned multiplicand.
- `in_b` in 8: unsigned multiplier.
- `out_valid` out 1: result valid; registered.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out ACC_W: sum of LEN products, modulo 2^ACC_W.
- `out_ovf` out 1: at least one carry out of bit ACC_W-1 occurred while forming `out_data`.

## Operation
- A pair is accepted when `in_valid & in_ready` is true at an edge.
- Data path:
  - S1 register: `a_q`, `b_q`, valid `v1`, last tag `l1`.
  - The multiplier instance sits combinationally between S1 and S2.
  - S2 register: `p_q[15:0]`, `v2`, `l2`.
  - Accumulator: `acc[ACC_W-1:0]` plus sticky `ovf_acc`.
- Accept counter `cnt`:
  - Range 0..LEN-1; increments on each accepted pair.
  - The pair accepted at `cnt==LEN-1` is tagged last (`l1=1`), and `cnt` wraps to 0.
- Accumulate: when `v2=1`, `{carry, acc} <= acc + p_q` (p_q zero-extended) and `ovf_acc <= ovf_acc | carry`.
- Finish: when `v2 & l2`:
  - `out_data <= acc + p_q` and `out_ovf <= ovf_acc | carry`.
  - `out_valid <= 1`.
  - `acc <= 0` and `ovf_acc <= 0`, all on the same edge.
- FSM:
  - IDLE: reset state; goes to ACCUM unconditionally on the next edge. `in_ready=0`.
  - ACCUM: `in_ready=1`. On accepting the last pair, `in_ready` drops to 0 and the FSM goes to DRAIN.
  - DRAIN: `in_ready=0`. On the edge where `v2 & l2`, goes to HOLD; `out_valid` rises on that same edge.
  - HOLD: `out_valid=1`, `in_ready=0`. On `out_valid & out_ready`, `out_valid` drops to 0, `in_ready` rises to 1, and the FSM goes to ACCUM.
- Holding rules:
  - `out_data` and `out_ovf` hold stable while `out_valid=1`.
  - `in_a` and `in_b` are ignored whenever `in_ready=0`.
- Input bubbles (`in_valid=0` in ACCUM) push `v1=0` through the pipeline and do not change `acc`.
- `LEN=1`: every accepted pair is last; ACCUM goes to DRAIN after one pair.
- Widths: products are always exact (16 bits). The sum wraps modulo 2^ACC_W; setting `ACC_W >= 16+ceil(log2(LEN))` guarantees `out_ovf=0`.

## Timing
- Reset values, held throughout any cycle with `rst_n=0` and after the reset edge:
  - `in_ready=0`, `out_valid=0`, `out_data=0`, `out_ovf=0`.
  - `cnt=0`, `acc=0`, `ovf_acc=0`, `v1=v2=0`, `l1=l2=0`; FSM in IDLE.
- First cycle after release: `in_ready` is still 0 (IDLE). It reaches 1 one edge later.
- Latency: last pair accepted at edge E gives `out_valid=1` after edge E+2, i.e. visible in the third cycle after the handshake cycle.
- Throughput:
  - One pair per cycle in ACCUM.
  - Minimum result period is LEN+3 cycles with `out_ready` held high: LEN accepts, 2 drain cycles, 1 output handshake cycle.
- Reset mid-operation: all partial sums, in-flight pipeline data and any pending result are discarded; no output is produced for the interrupted group.
- `out_ready` high outside HOLD has no effect.

## Test plan
- LEN=4, ACC_W=24; pairs (255,255) ×4 back-to-back, `out_ready=1` -> `out_data=260100` (0x03F804), `out_ovf=0`; `out_valid` high for 1 cycle, 3 cycles after the 4th handshake.
- Pairs (1,2),(3,4),(5,6),(7,8), then (0,0),(0,0),(0,0),(1,1) -> first result 100, second result 1; the second group confirms the accumulator cleared.
- Same first group with `in_valid` deasserted for 3 cycles between pairs 2 and 3 -> `out_data=100`, same 3-cycle latency after the last handshake.
- `out_ready=0` for 5 cycles after `out_valid` rises:
  - `out_data` stays 100, `in_ready` stays 0, no pair is consumed.
  - After the `out_ready=1` handshake edge: `in_ready=1`, and the next group sums from 0.
- Assert `rst_n=0` for 1 cycle after 2 accepted pairs of (10,10) -> all outputs 0; the next 4 pairs (2,3) give `out_data=24`.
- ACC_W=17, LEN=4; pairs (255,255) ×4 -> `out_data=129028`, `out_ovf=1`; the next group (1,1) ×4 -> `out_data=4`, `out_ovf=0`.
